microwave_timer: RTL and testbench

Cook-time countdown that feeds the microwave controller's `finish` input. It accepts minute/ten-second increment buttons, counts down one second per prescaled tick while the controller's `heat` is high, and raises `finish` when the time reaches 00:00. It also drives the mm:ss values for the front-panel display.

---
 rtl/mwt_pkg.sv | 20 ++
 rtl/mwt_prescaler.sv | 30 +++
 rtl/microwave_timer.sv | 124 ++++++++++++
 tb/tb_microwave_timer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mwt_pkg.sv
// Shared types and constants for the microwave cook-time countdown.
// QUICK_STEP exists only when MWT_QUICKSTART_EN is defined.
package mwt_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ARMED  = 2'd1,
        RUN    = 2'd2,
        PAUSED = 2'd3
    } mwt_state_t;

    localparam int unsigned MIN_W        = 7;
    localparam int unsigned SEC_W        = 6;
    localparam int unsigned SEC_MAX      = 59;
    localparam int unsigned ADD_SEC_STEP = 10;
`ifdef MWT_QUICKSTART_EN
    localparam int unsigned QUICK_STEP   = 30;
`endif

endpackage

// File: rtl/mwt_prescaler.sv
// One-second prescaler: counts clock cycles while run is high, holds otherwise.
// tick marks the last cycle of each second; mid_second flags a partial second.
module mwt_prescaler #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick,
    output logic mid_second
);

    localparam int unsigned   CW   = $clog2(TICKS_PER_SEC);
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (run) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

    assign tick       = run && (count == LAST);
    assign mid_second = (count != '0);

endmodule

// File: rtl/microwave_timer.sv
// Cook-time countdown (mm:ss) driving the controller's finish input.
// Optional quick-start button (+30 s) enabled by defining MWT_QUICKSTART_EN.
module microwave_timer
    import mwt_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned MAX_MIN       = 99
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             add_min,
    input  logic             add_sec,
    input  logic             clear,
`ifdef MWT_QUICKSTART_EN
    input  logic             quick,
`endif
    input  logic             heat,
    output logic             finish,
    output logic [MIN_W-1:0] minutes,
    output logic [SEC_W-1:0] seconds,
    output logic             armed
);

    mwt_state_t       state, state_nxt;
    logic             tick, mid_second, presc_clr;
    logic             clr_req, quick_req, any_add, time_nxt_zero;
    logic [SEC_W:0]   quick_add;
    logic [MIN_W-1:0] min_dec, min_nxt;
    logic [SEC_W-1:0] sec_dec, sec_nxt;
    logic [SEC_W:0]   sec_sum;
    logic [MIN_W:0]   min_sum;

`ifdef MWT_QUICKSTART_EN
    assign quick_req = quick && (state != RUN);
    assign quick_add = quick_req ? (SEC_W+1)'(QUICK_STEP) : '0;
`else
    assign quick_req = 1'b0;
    assign quick_add = '0;
`endif

    assign clr_req = clear && (state != RUN);
    assign any_add = add_min || add_sec || quick_req;

    mwt_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_presc (
        .clk       (clk),
        .rst       (rst),
        .run       (state == RUN),
        .clr       (presc_clr),
        .tick      (tick),
        .mid_second(mid_second)
    );

    // Tick decrement first, then adds with a single carry, then saturation.
    always_comb begin
        min_dec = minutes;
        sec_dec = seconds;
        if (tick) begin
            if (seconds != '0) begin
                sec_dec = seconds - 1'b1;
            end else begin
                min_dec = minutes - 1'b1;
                sec_dec = SEC_W'(SEC_MAX);
            end
        end
        sec_sum = {1'b0, sec_dec} + (add_sec ? (SEC_W+1)'(ADD_SEC_STEP) : '0) + quick_add;
        min_sum = {1'b0, min_dec} + (MIN_W+1)'(add_min);
        if (sec_sum > (SEC_W+1)'(SEC_MAX)) begin
            sec_sum = sec_sum - (SEC_W+1)'(SEC_MAX + 1);
            min_sum = min_sum + 1'b1;
        end
        if (min_sum > (MIN_W+1)'(MAX_MIN)) begin
            min_nxt = MIN_W'(MAX_MIN);
            sec_nxt = SEC_W'(SEC_MAX);
        end else begin
            min_nxt = min_sum[MIN_W-1:0];
            sec_nxt = sec_sum[SEC_W-1:0];
        end
        if (clr_req) begin
            min_nxt = '0;
            sec_nxt = '0;
        end
    end

    assign time_nxt_zero = (min_nxt == '0) && (sec_nxt == '0);

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: begin
                if (!clr_req && any_add) state_nxt = ARMED;
            end
            ARMED, PAUSED: begin
                if (clr_req)   state_nxt = EMPTY;
                else if (heat) state_nxt = RUN;
                else           state_nxt = mid_second ? PAUSED : ARMED;
            end
            RUN: begin
                // Leaving on a tick edge lands on a whole second (prescaler wraps to 0).
                if (time_nxt_zero) state_nxt = EMPTY;
                else if (!heat)    state_nxt = tick ? ARMED : PAUSED;
            end
        endcase
    end

    assign presc_clr = (state_nxt == EMPTY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            minutes <= '0;
            seconds <= '0;
        end else begin
            state   <= state_nxt;
            minutes <= min_nxt;
            seconds <= sec_nxt;
        end
    end

    assign armed  = (minutes != '0) || (seconds != '0);
    assign finish = heat && !armed;

endmodule

// File: tb/tb_microwave_timer.sv
// Bench for microwave_timer (TICKS_PER_SEC=4): directed scenarios plus random
// pulses, checked each cycle against a total-seconds reference model.
module tb_microwave_timer;
    import mwt_pkg::*;

    localparam int unsigned T    = 4;
    localparam int unsigned MAXT = 99 * 60 + 59;

    logic       clk;
    logic       rst, add_min, add_sec, clear, heat, quick;
    logic       finish, armed;
    logic [6:0] minutes;
    logic [5:0] seconds;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: total seconds, partial-second count, counting flag.
    int unsigned m_t, m_pc;
    bit          m_run;

    microwave_timer #(
        .TICKS_PER_SEC(T),
        .MAX_MIN      (99)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .add_min(add_min),
        .add_sec(add_sec),
        .clear  (clear),
`ifdef MWT_QUICKSTART_EN
        .quick  (quick),
`endif
        .heat   (heat),
        .finish (finish),
        .minutes(minutes),
        .seconds(seconds),
        .armed  (armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic mwt_state_t m_state();
        if (m_t == 0)  return EMPTY;
        if (m_run)     return RUN;
        if (m_pc != 0) return PAUSED;
        return ARMED;
    endfunction

    task automatic step();
        int unsigned nt;
        bit          tk;
        tk = m_run && (m_pc == T - 1);
        nt = m_t;
        if (tk) nt = nt - 1;
        if (clear && !m_run) begin
            nt = 0;
        end else begin
            nt = nt + (add_min ? 60 : 0) + (add_sec ? 10 : 0);
            if (nt > MAXT) nt = MAXT;
        end
        if (rst) begin
            m_t = 0; m_pc = 0; m_run = 1'b0;
        end else begin
            m_pc  = (nt == 0) ? 0 : (m_run ? (tk ? 0 : m_pc + 1) : m_pc);
            m_run = heat && (m_t != 0) && (nt != 0);
            m_t   = nt;
        end
        @(posedge clk);
        #1;
        chk("min",    32'(minutes), m_t / 60);
        chk("sec",    32'(seconds), m_t % 60);
        chk("armed",  32'(armed), 32'(m_t != 0));
        chk("finish", 32'(finish), 32'(heat && (m_t == 0)));
        chk("state",  32'(dut.state), 32'(m_state()));
        chk("presc",  32'(dut.u_presc.count), m_pc);
    endtask

    initial begin
        int n;
        rst = 1'b1; add_min = 1'b0; add_sec = 1'b0; clear = 1'b0; heat = 1'b0; quick = 1'b0;
        m_t = 0; m_pc = 0; m_run = 1'b0;
        step();
        rst = 1'b0;
        chk("rst_min", 32'(minutes), 0);
        chk("rst_sec", 32'(seconds), 0);
        chk("rst_fin", 32'(finish), 0);
        chk("rst_armed", 32'(armed), 0);
        chk("rst_state", 32'(dut.state), 32'(EMPTY));

        // Basic countdown from 00:10
        add_sec = 1'b1; step(); add_sec = 1'b0;
        chk("bc_load", 32'(seconds), 10);
        heat = 1'b1; step();
        n = 0;
        while (finish !== 1'b1 && n < 100) begin step(); n++; end
        chk("bc_fin_lat", n, 40);
        chk("bc_state", 32'(dut.state), 32'(EMPTY));
        chk("bc_armed", 32'(armed), 0);
        heat = 1'b0; step();

        // Carry and saturation
        rst = 1'b1; step(); rst = 1'b0;
        add_sec = 1'b1; repeat (7) step(); add_sec = 1'b0;
        chk("cs_min", 32'(minutes), 1);
        chk("cs_sec", 32'(seconds), 10);
        add_min = 1'b1; repeat (120) step(); add_min = 1'b0;
        chk("sat_min", 32'(minutes), 99);
        chk("sat_sec", 32'(seconds), 59);

        // Pause with a partial second at 00:02
        rst = 1'b1; step(); rst = 1'b0;
        add_sec = 1'b1; step(); add_sec = 1'b0;
        heat = 1'b1;
        n = 0;
        while (seconds != 6'd2 && n < 100) begin step(); n++; end
        chk("pa_reach", 32'(seconds), 2);
        step();
        heat = 1'b0; step();
        repeat (10) step();
        chk("pa_hold_sec", 32'(seconds), 2);
        chk("pa_hold_state", 32'(dut.state), 32'(PAUSED));
        heat = 1'b1; step();
        n = 0;
        while (seconds == 6'd2 && n < 20) begin step(); n++; end
        chk("pa_resume", n, 2);
        heat = 1'b0; step();

        // Empty start, then clear during RUN
        rst = 1'b1; step(); rst = 1'b0;
        heat = 1'b1; #1;
        chk("es_fin_same", 32'(finish), 1);
        repeat (3) step();
        chk("es_sec", 32'(seconds), 0);
        chk("es_min", 32'(minutes), 0);
        add_sec = 1'b1; step(); add_sec = 1'b0;
        step();
        clear = 1'b1; step(); clear = 1'b0;
        chk("clr_run_sec", 32'(seconds), 10);
        chk("clr_run_state", 32'(dut.state), 32'(RUN));
        heat = 1'b0; step();

        // Add coinciding with the tick that reaches 00:00
        rst = 1'b1; step(); rst = 1'b0;
        add_sec = 1'b1; step(); add_sec = 1'b0;
        heat = 1'b1;
        n = 0;
        while (seconds != 6'd1 && n < 100) begin step(); n++; end
        chk("sc_reach", 32'(seconds), 1);
        repeat (3) step();
        add_sec = 1'b1; step(); add_sec = 1'b0;
        chk("sc_sec", 32'(seconds), 10);
        chk("sc_fin", 32'(finish), 0);
        chk("sc_state", 32'(dut.state), 32'(RUN));
        heat = 1'b0; step();

        // Reset mid-count at 05:37
        rst = 1'b1; step(); rst = 1'b0;
        add_min = 1'b1; repeat (5) step(); add_min = 1'b0;
        add_sec = 1'b1; repeat (4) step(); add_sec = 1'b0;
        heat = 1'b1;
        n = 0;
        while (seconds != 6'd37 && n < 200) begin step(); n++; end
        chk("rm_reach", 32'(seconds), 37);
        step(); step();
        rst = 1'b1; heat = 1'b0; step(); rst = 1'b0;
        chk("rm_min", 32'(minutes), 0);
        chk("rm_sec", 32'(seconds), 0);
        chk("rm_fin", 32'(finish), 0);
        chk("rm_presc", 32'(dut.u_presc.count), 0);
        chk("rm_state", 32'(dut.state), 32'(EMPTY));

        // Random pulses against the model
        repeat (600) begin
            add_min = ($urandom_range(15) == 0);
            add_sec = ($urandom_range(7) == 0);
            clear   = ($urandom_range(15) == 0);
            rst     = ($urandom_range(199) == 0);
            if ($urandom_range(19) == 0) heat = ~heat;
            step();
        end
        rst = 1'b0; add_min = 1'b0; add_sec = 1'b0; clear = 1'b0; heat = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
